// File: rtl/line_raster_engine_if.sv
// line_raster_engine_if: host command and pixel-write handshake bundle for the line raster engine
interface line_raster_engine_if #(
   parameter int X_W = 9,
   parameter int Y_W = 8
);
   logic Go, Mode, Abort, Busy, Done, Draw, Write_Finish;
   logic [X_W-1:0] X0, X1;
   logic [Y_W-1:0] Y0, Y1;
   logic [31:0] Pixel_Address;
   logic [X_W+Y_W:0] Pixel_Count;
   modport master(output Go, Mode, Abort, X0, X1, Y0, Y1, Write_Finish,
                  input Busy, Done, Draw, Pixel_Address, Pixel_Count);
   modport slave(input Go, Mode, Abort, X0, X1, Y0, Y1, Write_Finish,
                 output Busy, Done, Draw, Pixel_Address, Pixel_Count);
endinterface

// File: rtl/line_raster_engine.sv
// line_raster_engine: Bresenham line / filled rectangle pixel walker issuing one framebuffer write per pixel
module line_raster_engine #(
   parameter int X_W = 9,
   parameter int Y_W = 8,
   parameter logic [31:0] BASE_ADDR = 32'h08000000,
   parameter int PIX_SHIFT = 1
) (
   input logic clk,
   input logic resetn,
   line_raster_engine_if.slave bus
);
   localparam int M = (X_W > Y_W) ? X_W : Y_W;
   localparam int C_W = X_W + Y_W + 1;
   typedef enum logic [2:0] {IDLE, SETUP, WAIT, STEP, DONE} state_t;
   state_t state, state_n;
   logic mode, steep, neg, abort_pend, stp, sw, last, stop;
   logic [X_W-1:0] x0, x1, sx;
   logic [Y_W-1:0] y0, y1, sy;
   logic [M-1:0] cur_a, cur_b, a_lo, a_end, b_end, dmaj, dmin;
   logic [M-1:0] ex0, ex1, ey0, ey1, adx, ady, pa0, pa1, pb0, pb1, a0, a1, b0, b1, dmj;
   logic [M-1:0] xmn, xmx, ymn, ymx;
   logic signed [M+1:0] err, err_n;
   logic [C_W-1:0] count;
   always_comb begin
      ex0 = M'(x0);
      ex1 = M'(x1);
      ey0 = M'(y0);
      ey1 = M'(y1);
      adx = ex1 >= ex0 ? ex1 - ex0 : ex0 - ex1;
      ady = ey1 >= ey0 ? ey1 - ey0 : ey0 - ey1;
      stp = ady > adx;
      pa0 = stp ? ey0 : ex0;
      pa1 = stp ? ey1 : ex1;
      pb0 = stp ? ex0 : ey0;
      pb1 = stp ? ex1 : ey1;
      sw = pa0 > pa1;
      a0 = sw ? pa1 : pa0;
      a1 = sw ? pa0 : pa1;
      b0 = sw ? pb1 : pb0;
      b1 = sw ? pb0 : pb1;
      dmj = a1 - a0;
      xmn = ex0 < ex1 ? ex0 : ex1;
      xmx = ex0 < ex1 ? ex1 : ex0;
      ymn = ey0 < ey1 ? ey0 : ey1;
      ymx = ey0 < ey1 ? ey1 : ey0;
      err_n = err + $signed({2'b00, dmin});
      last = cur_a == a_end && (!mode || cur_b == b_end);
      stop = bus.Abort || abort_pend;
      sx = X_W'(steep ? cur_b : cur_a);
      sy = Y_W'(steep ? cur_a : cur_b);
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = bus.Go ? SETUP : IDLE;
         SETUP: state_n = stop ? DONE : WAIT;
         WAIT: state_n = !bus.Write_Finish ? WAIT : (last || stop) ? DONE : STEP;
         STEP: state_n = stop ? DONE : WAIT;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) state <= !resetn ? IDLE : state_n;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mode <= 1'b0;
         steep <= 1'b0;
         neg <= 1'b0;
         abort_pend <= 1'b0;
         x0 <= '0;
         x1 <= '0;
         y0 <= '0;
         y1 <= '0;
         cur_a <= '0;
         cur_b <= '0;
         a_lo <= '0;
         a_end <= '0;
         b_end <= '0;
         dmaj <= '0;
         dmin <= '0;
         err <= '0;
         count <= '0;
      end else begin
         if (state == IDLE && bus.Go) begin
            mode <= bus.Mode;
            x0 <= bus.X0;
            x1 <= bus.X1;
            y0 <= bus.Y0;
            y1 <= bus.Y1;
            abort_pend <= 1'b0;
            count <= '0;
         end else if (state != IDLE && bus.Abort) begin
            abort_pend <= 1'b1;
         end
         if (state == SETUP) begin
            steep <= !mode && stp;
            cur_a <= mode ? xmn : a0;
            cur_b <= mode ? ymn : b0;
            a_lo <= xmn;
            a_end <= mode ? xmx : a1;
            b_end <= ymx;
            dmaj <= dmj;
            dmin <= b1 >= b0 ? b1 - b0 : b0 - b1;
            neg <= b1 < b0;
            err <= -$signed({2'b00, dmj >> 1});
         end
         if (state == WAIT && bus.Write_Finish) count <= count + C_W'(1);
         if (state == STEP && mode) begin
            cur_a <= cur_a == a_end ? a_lo : cur_a + M'(1);
            if (cur_a == a_end) cur_b <= cur_b + M'(1);
         end
         if (state == STEP && !mode) begin
            cur_a <= cur_a + M'(1);
            cur_b <= err_n > 0 ? (neg ? cur_b - M'(1) : cur_b + M'(1)) : cur_b;
            err <= err_n > 0 ? err_n - $signed({2'b00, dmaj}) : err_n;
         end
      end
   end
   assign bus.Busy = state != IDLE;
   assign bus.Done = state == DONE;
   assign bus.Draw = state == WAIT;
   assign bus.Pixel_Count = count;
   assign bus.Pixel_Address = BASE_ADDR | (32'(sy) << (X_W + PIX_SHIFT)) | (32'(sx) << PIX_SHIFT);
endmodule

// File: tb/tb_line_raster_engine.sv
// tb_line_raster_engine: scoreboard bench driving primitives and checking every written pixel address
module tb_line_raster_engine;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   line_raster_engine_if #(.X_W(9), .Y_W(8)) bus();
   line_raster_engine #(.X_W(9), .Y_W(8), .BASE_ADDR(32'h08000000), .PIX_SHIFT(1)) dut(
      .clk(clk), .resetn(resetn), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] pa(input int x, input int y);
      return 32'h08000000 | (32'(y) << 10) | (32'(x) << 1);
   endfunction
   task automatic start(input logic m, input int x0, input int y0, input int x1, input int y1);
      bus.Mode = m;
      bus.X0 = 9'(x0);
      bus.Y0 = 8'(y0);
      bus.X1 = 9'(x1);
      bus.Y1 = 8'(y1);
      bus.Go = 1'b1;
      @(posedge clk);
      #1;
      bus.Go = 1'b0;
   endtask
   task automatic serve(input int delay, input int abort_at, input bit stray,
                        output int draws, output int dones, output int first);
      int wc = 0;
      bit prev = 1'b0;
      bit fin = 1'b0;
      logic [31:0] e;
      draws = 0;
      dones = 0;
      first = -1;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(posedge clk);
         #1;
         bus.Write_Finish = 1'b0;
         bus.Abort = 1'b0;
         if (bus.Done) dones++;
         if (!bus.Busy) fin = 1'b1;
         else if (bus.Draw) begin
            if (!prev) begin
               draws++;
               wc = 0;
               if (first < 0) first = cyc;
            end
            wc++;
            if (draws == abort_at && wc == 1) bus.Abort = 1'b1;
            if (wc == delay) begin
               bus.Write_Finish = 1'b1;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL extra_draw: got address %h, expected no further pixel", bus.Pixel_Address);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.Pixel_Address !== e) begin
                     errors++;
                     $display("FAIL pixel_address: got %h, expected %h", bus.Pixel_Address, e);
                  end
               end
            end
         end else bus.Write_Finish = stray;
         prev = bus.Draw;
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL timeout: got busy after 400 cycles, expected idle");
      end
   endtask
   task automatic check_end(input string name, input int draws, input int dones, input int n);
      checks += 4;
      if (draws != n) begin errors++; $display("FAIL %s_draws: got %0d, expected %0d", name, draws, n); end
      if (dones != 1) begin errors++; $display("FAIL %s_done: got %0d pulses, expected 1", name, dones); end
      if (bus.Pixel_Count !== 18'(n)) begin errors++; $display("FAIL %s_count: got %0d, expected %0d", name, bus.Pixel_Count, n); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL %s_missing: got %0d pixels undrawn, expected 0", name, exp_q.size()); end
   endtask
   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks += 5;
      if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus.Busy); end
      if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", bus.Done); end
      if (bus.Draw !== 1'b0) begin errors++; $display("FAIL reset_draw: got %b, expected 0", bus.Draw); end
      if (bus.Pixel_Address !== 32'h08000000) begin errors++; $display("FAIL reset_addr: got %h, expected 08000000", bus.Pixel_Address); end
      if (bus.Pixel_Count !== '0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", bus.Pixel_Count); end
      resetn = 1'b1;
   endtask
   task automatic test_line;
      int d, n, f;
      exp_q = '{pa(0, 0), pa(1, 0), 32'h08000404, pa(3, 1), pa(4, 2)};
      start(1'b0, 0, 0, 4, 2);
      checks += 2;
      if (bus.Busy !== 1'b1 || bus.Draw !== 1'b0) begin
         errors++;
         $display("FAIL setup_state: got busy=%b draw=%b, expected busy=1 draw=0", bus.Busy, bus.Draw);
      end
      serve(1, 0, 1'b0, d, n, f);
      if (f != 0) begin errors++; $display("FAIL draw_latency: got first draw at %0d, expected 0", f); end
      check_end("line", d, n, 5);
   endtask
   task automatic test_steep;
      int d, n, f;
      for (int y = 0; y <= 5; y++) exp_q.push_back(pa(5, y));
      start(1'b0, 5, 5, 5, 0);
      checks++;
      if (bus.Pixel_Count !== '0) begin errors++; $display("FAIL count_clear: got %0d, expected 0", bus.Pixel_Count); end
      serve(2, 0, 1'b0, d, n, f);
      check_end("steep", d, n, 6);
   endtask
   task automatic test_rect;
      int d, n, f;
      exp_q = '{pa(2, 3), pa(3, 3), pa(4, 3), pa(2, 4), pa(3, 4), pa(4, 4)};
      start(1'b1, 4, 4, 2, 3);
      serve(2, 0, 1'b1, d, n, f);
      check_end("rect", d, n, 6);
   endtask
   task automatic test_degenerate;
      int d, n, f;
      for (int m = 0; m < 2; m++) begin
         exp_q.push_back(32'h08002814);
         start(m[0], 10, 10, 10, 10);
         serve(1, 0, 1'b0, d, n, f);
         check_end(m == 0 ? "point_line" : "point_rect", d, n, 1);
      end
   endtask
   task automatic test_abort;
      int d, n, f;
      exp_q = '{pa(0, 0), pa(1, 0), pa(2, 0)};
      start(1'b0, 0, 0, 8, 0);
      serve(4, 3, 1'b0, d, n, f);
      check_end("abort", d, n, 3);
   endtask
   task automatic test_reset_mid;
      int d, n, f;
      exp_q.delete();
      start(1'b0, 0, 0, 8, 0);
      @(posedge clk);
      #1;
      checks++;
      if (bus.Draw !== 1'b1) begin errors++; $display("FAIL mid_draw: got %b, expected 1", bus.Draw); end
      resetn = 1'b0;
      @(posedge clk);
      #1;
      checks += 4;
      if (bus.Draw !== 1'b0) begin errors++; $display("FAIL mid_reset_draw: got %b, expected 0", bus.Draw); end
      if (bus.Busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b, expected 0", bus.Busy); end
      if (bus.Done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b, expected 0", bus.Done); end
      if (bus.Pixel_Count !== '0) begin errors++; $display("FAIL mid_reset_count: got %0d, expected 0", bus.Pixel_Count); end
      resetn = 1'b1;
      exp_q = '{pa(1, 1), pa(2, 1)};
      start(1'b1, 1, 1, 2, 1);
      serve(1, 0, 1'b0, d, n, f);
      check_end("after_reset", d, n, 2);
   endtask
   task automatic test_back_to_back;
      int d, n, f;
      exp_q = '{pa(0, 0), pa(1, 1), pa(2, 2)};
      bus.Mode = 1'b0;
      bus.X0 = 9'd0;
      bus.Y0 = 8'd0;
      bus.X1 = 9'd2;
      bus.Y1 = 8'd2;
      bus.Go = 1'b1;
      @(posedge clk);
      #1;
      bus.Mode = 1'b1;
      bus.X0 = 9'd3;
      bus.Y0 = 8'd0;
      bus.X1 = 9'd3;
      bus.Y1 = 8'd1;
      serve(1, 0, 1'b0, d, n, f);
      check_end("b2b_first", d, n, 3);
      exp_q = '{pa(3, 0), pa(3, 1)};
      @(posedge clk);
      #1;
      bus.Go = 1'b0;
      checks++;
      if (bus.Busy !== 1'b1 || bus.Pixel_Count !== '0) begin
         errors++;
         $display("FAIL b2b_restart: got busy=%b count=%0d, expected busy=1 count=0", bus.Busy, bus.Pixel_Count);
      end
      serve(1, 0, 1'b0, d, n, f);
      check_end("b2b_second", d, n, 2);
   endtask
   initial begin
      bus.Go = 1'b0;
      bus.Mode = 1'b0;
      bus.Abort = 1'b0;
      bus.Write_Finish = 1'b0;
      bus.X0 = '0;
      bus.X1 = '0;
      bus.Y0 = '0;
      bus.Y1 = '0;
      test_reset;
      test_line;
      test_steep;
      test_rect;
      test_degenerate;
      test_abort;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
